// File: rtl/chunked_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_ripple_adder
// Brief    : Multi-cycle ripple-carry adder/subtractor. Processes CHUNK bits
//            per clock through a row of full-adder cells and carries the
//            ripple carry across cycles in a register. Valid/ready handshake
//            on both sides, one operation in flight.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_ripple_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(NCHUNK - 1);

    // Reject illegal geometry at elaboration time
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_ripple_adder: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;        // already inverted for subtraction
    logic [WIDTH-1:0] r_sum;      // internal partial sum, not visible outside
    logic [WIDTH:0]   r_result;   // output register, loaded on entry to DONE
    logic             r_overflow;
    logic             r_ready;
    logic             r_valid;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic [CHUNK:0]   w_c;        // w_c[i] is the carry into bit i of the chunk
    logic [WIDTH-1:0] w_sum_next;

    // Operand slices for the chunk currently being processed
    assign w_a_chunk = r_a[r_cnt*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_cnt*CHUNK +: CHUNK];
    assign w_c[0]    = r_carry;

    // One full-adder cell per bit of the chunk, carries rippling upward
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign w_s[i]     = w_a_chunk[i] ^ w_b_chunk[i] ^ w_c[i];
        assign w_c[i + 1] = (w_a_chunk[i] & w_b_chunk[i])
                          | (w_c[i] & (w_a_chunk[i] ^ w_b_chunk[i]));
    end

    // Sum register with the current chunk merged in, so the final chunk can
    // be written straight to the output register in the same edge
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[r_cnt*CHUNK +: CHUNK] = w_s;
    end

    // Control FSM and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_a     <= i_add_term1;
                        r_b     <= i_sub ? ~i_add_term2 : i_add_term2;
                        r_carry <= i_sub ? 1'b1 : i_carry;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_c[CHUNK];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // Signed overflow: carry into MSB differs from carry out
                        r_result   <= {w_c[CHUNK], w_sum_next};
                        r_overflow <= w_c[CHUNK] ^ w_c[CHUNK-1];
                        r_valid    <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_valid    = r_valid;
    assign o_result   = r_result;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_chunked_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_ripple_adder
// Brief    : Self-checking bench: directed vector table on an 8/2 instance,
//            back-pressure and mid-run reset sequences, and a random sweep
//            over several WIDTH/CHUNK geometries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_ripple_adder;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_add_term1;
    logic [7:0] i_add_term2;
    logic       i_carry;
    logic       i_sub;
    logic       o_valid;
    logic       i_ready;
    logic [8:0] o_result;
    logic       o_overflow;

    logic       rst_sw_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunked_ripple_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .i_carry     (i_carry),
        .i_sub       (i_sub),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_overflow  (o_overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [8:0] res;
        logic       ov;
        string      tag;
    } vec_t;

    // Issue one operation on the 8/2 instance and check result and latency
    task automatic run_op(input vec_t v);
        int lat;
        i_add_term1 = v.a;
        i_add_term2 = v.b;
        i_carry     = v.cin;
        i_sub       = v.sub;
        i_valid     = 1'b1;
        @(posedge clk); #1;
        i_valid     = 1'b0;
        i_add_term1 = ~v.a;
        i_add_term2 = ~v.b;
        i_sub       = ~v.sub;
        lat = 0;
        while (!o_valid && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        check({v.tag, "_lat"}, 64'(lat), 64'd4);
        check({v.tag, "_res"}, 64'(o_result), 64'(v.res));
        check({v.tag, "_ov"},  64'(o_overflow), 64'(v.ov));
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check({v.tag, "_rdy"}, {62'd0, o_ready, o_valid}, 64'b10);
    endtask

    // ------------------------------------------------------------------
    // Random sweep over other geometries, each with its own instance
    // ------------------------------------------------------------------
    initial begin
        rst_sw_n = 1'b0;
        #22 rst_sw_n = 1'b1;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int W = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 16 : 32;
        localparam int C = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 4  : 8;
        localparam int N = W / C;

        logic         s_vin, s_rdy_out, s_cin, s_sub, s_vout, s_rin, s_ov;
        logic [W-1:0] s_a, s_b;
        logic [W:0]   s_res;
        logic         s_done = 1'b0;

        chunked_ripple_adder #(.WIDTH(W), .CHUNK(C)) u_sw (
            .i_clk       (clk),
            .i_rst_n     (rst_sw_n),
            .i_valid     (s_vin),
            .o_ready     (s_rdy_out),
            .i_add_term1 (s_a),
            .i_add_term2 (s_b),
            .i_carry     (s_cin),
            .i_sub       (s_sub),
            .o_valid     (s_vout),
            .i_ready     (s_rin),
            .o_result    (s_res),
            .o_overflow  (s_ov)
        );

        initial begin : p_sweep
            logic [63:0]  rnd;
            logic [W-1:0] bb;
            logic [W:0]   exp_res;
            logic         exp_ov;
            int           lat;
            s_vin = 1'b0; s_rin = 1'b0; s_cin = 1'b0; s_sub = 1'b0;
            s_a = '0; s_b = '0;
            repeat (4) @(posedge clk);
            #1;
            for (int n = 0; n < 1000; n++) begin
                rnd   = {$urandom, $urandom};
                s_a   = rnd[W-1:0];
                rnd   = {$urandom, $urandom};
                s_b   = rnd[W-1:0];
                s_sub = 1'($urandom_range(0, 1));
                s_cin = 1'($urandom_range(0, 1));
                bb      = s_sub ? ~s_b : s_b;
                exp_res = {1'b0, s_a} + {1'b0, bb} + (W+1)'(s_sub ? 1'b1 : s_cin);
                exp_ov  = (s_a[W-1] == bb[W-1]) && (exp_res[W-1] != s_a[W-1]);
                s_vin = 1'b1;
                @(posedge clk); #1;
                s_vin = 1'b0;
                lat = 0;
                while (!s_vout && lat < 64) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check($sformatf("sw%0d_lat", g), 64'(lat), 64'(N));
                check($sformatf("sw%0d_res", g), 64'(s_res), 64'(exp_res));
                check($sformatf("sw%0d_ov", g),  64'(s_ov), 64'(exp_ov));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0 s_rin = 1'b1;
                @(posedge clk); #1;
                s_rin = 1'b0;
            end
            s_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed tests on the 8/2 instance
    // ------------------------------------------------------------------
    initial begin : p_main
        vec_t vecs[12];
        logic ok;
        int   lat;
        int   wd;

        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0, "add_ff_01"};
        vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1, "add_7f_01"};
        vecs[2]  = '{8'h10, 8'h20, 1'b1, 1'b0, 9'h031, 1'b0, "add_10_20_c"};
        vecs[3]  = '{8'h05, 8'h07, 1'b1, 1'b1, 9'h0FE, 1'b0, "sub_05_07"};
        vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 9'h17F, 1'b1, "sub_80_01"};
        vecs[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0, "add_zero"};
        vecs[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 9'h100, 1'b1, "add_80_80"};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b0, "add_ff_ff_c"};
        vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 9'h100, 1'b0, "sub_zero"};
        vecs[9]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 9'h080, 1'b1, "sub_7f_ff"};
        vecs[10] = '{8'h55, 8'hAA, 1'b1, 1'b0, 9'h100, 1'b0, "add_55_aa_c"};
        vecs[11] = '{8'h12, 8'h34, 1'b0, 1'b1, 9'h0DE, 1'b0, "sub_12_34"};

        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_add_term1 = 8'h00; i_add_term2 = 8'h00; i_carry = 1'b0; i_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_ov", 64'(o_overflow), 64'd0);
        i_rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // Back-pressure: result held, ready low, stray i_valid ignored
        i_add_term1 = 8'h10; i_add_term2 = 8'h20; i_carry = 1'b1; i_sub = 1'b0;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 64'(lat), 64'd4);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                i_add_term1 = 8'hEE; i_add_term2 = 8'h11; i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (!o_valid || o_ready || o_result !== 9'h031 || o_overflow !== 1'b0) ok = 1'b0;
        end
        i_valid = 1'b0;
        check("bp_hold", 64'(ok), 64'd1);
        check("bp_res", 64'(o_result), 64'h031);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("bp_release", {62'd0, o_ready, o_valid}, 64'b10);
        ok = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_valid || !o_ready) ok = 1'b0;
        end
        check("bp_pulse_ignored", 64'(ok), 64'd1);
        check("bp_res_kept", 64'(o_result), 64'h031);

        // Reset after two of four chunks
        i_add_term1 = 8'hAA; i_add_term2 = 8'h11; i_carry = 1'b0; i_sub = 1'b0;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_result", 64'(o_result), 64'd0);
        repeat (2) @(posedge clk);
        #4 i_rst_n = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_valid || !o_ready || o_result !== 9'h000) ok = 1'b0;
        end
        check("midrst_quiet", 64'(ok), 64'd1);
        run_op('{8'h03, 8'h04, 1'b0, 1'b0, 9'h007, 1'b0, "post_rst"});

        // Wait for the sweep instances, bounded
        wd = 0;
        while (!(g_sweep[0].s_done && g_sweep[1].s_done &&
                 g_sweep[2].s_done && g_sweep[3].s_done) && wd < 60000) begin
            @(posedge clk);
            wd++;
        end
        check("sweep_finished", 64'(wd < 60000), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chunked_ripple_adder.md
Name: chunked_ripple_adder

Overview:
- Parametrised multi-cycle ripple-carry adder/subtractor built from the team's full_adder cells.
- Adds two WIDTH-bit operands CHUNK bits per clock and registers the carry between chunks.
- Trades latency for a short critical path, so wide adds close timing without a carry-lookahead tree.
- Sits between operand producers and consumers. Uses a valid/ready handshake on input and output, and holds one operation in flight.

Parameters:
- WIDTH, 8, operand width in bits; >= 2.
- CHUNK, 2, bits processed per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0, otherwise an elaboration error.
- (derived) NCHUNK = WIDTH/CHUNK; counter width = max(1, clog2(NCHUNK)).

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operand request valid.
- o_ready  output  1  block can accept an operation.
- i_add_term1  input  WIDTH  operand A.
- i_add_term2  input  WIDTH  operand B.
- i_carry  input  1  carry-in; used only when i_sub=0.
- i_sub  input  1  1: compute A-B (A + ~B + 1); 0: A+B+i_carry.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  WIDTH+1  {carry_out, sum}; in subtract mode MSB=1 means no borrow.
- o_overflow  output  1  two's-complement signed overflow of the WIDTH-bit sum.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, o_valid=0, o_result=0, o_overflow=0, chunk counter=0, carry reg=0. o_ready=1 once in IDLE.
- States: IDLE, RUN, DONE. o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE:
  - On an edge with i_valid && o_ready: latch A, B' = i_sub ? ~B : B, carry reg = i_sub ? 1 : i_carry; counter=0; go to RUN.
  - Otherwise stay in IDLE; the operand inputs are don't-care.
- RUN, each edge:
  - sum[k*CHUNK +: CHUNK] and next carry = ripple of A chunk k + B' chunk k + carry reg (k = counter).
  - Carry reg updated; counter++.
  - When k == NCHUNK-1: capture carry_out and overflow = carry into MSB XOR carry out of MSB; go to DONE.
- Latency: o_valid rises exactly NCHUNK cycles after the accepting edge. With CHUNK=WIDTH, it rises 1 cycle after.
- DONE:
  - o_result and o_overflow are held stable while o_valid=1 && !i_ready (back-pressure, indefinitely).
  - On an edge with i_ready: go to IDLE. o_valid drops and o_ready rises the next cycle.
  - No new operation is accepted in the same cycle (o_ready=0 throughout DONE).
- o_result keeps its last value in IDLE/RUN. Partial sums are not visible until DONE; the sum register may update internally, but o_result is driven from a separate output register loaded on entry to DONE.
- Input changes while in RUN/DONE are ignored; operands are captured only at acceptance.
- i_valid while o_ready=0 is not lost-safe: the producer must hold i_valid until the handshake.
- Reset mid-RUN or mid-DONE: immediate return to the reset values; the in-flight operation is discarded and no o_valid pulse is produced. The first acceptance after deassert behaves normally.
- Arithmetic is modulo 2^WIDTH in the sum; carry_out is the true WIDTH+1 bit. No saturation.

Test Plan:
- WIDTH=8, CHUNK=2, add 0xFF + 0x01, carry 0 -> o_valid exactly 4 cycles after accept; o_result=0x100, o_overflow=0.
- WIDTH=8, CHUNK=2, add 0x7F + 0x01 carry 0 -> o_result=0x080, o_overflow=1. Add 0x10 + 0x20 carry 1 -> 0x031, o_overflow=0.
- WIDTH=8, CHUNK=2:
  - Subtract 0x05 - 0x07 (i_carry=1, must be ignored) -> o_result=0x0FE, no borrow bit 0, o_overflow=0.
  - Subtract 0x80 - 0x01 -> o_result=0x17F, o_overflow=1.
- Back-pressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_result stable, o_ready=0, and a pulse on i_valid is ignored. Raise i_ready -> o_ready=1 next cycle.
- Reset mid-RUN after 2 of 4 chunks -> o_valid stays 0, o_result=0, o_ready=1 after release. The next op 0x03 + 0x04 returns 0x007.
- Parameter sweep over (8,1), (8,8), (16,4), (32,8) with 1000 random operands, modes and carries plus back-pressure gaps -> every result matches A+B+cin or A-B (WIDTH+1 bits, overflow) and latency equals NCHUNK.
